pipe_ctrl: RTL

Central pipeline sequencer for the 5-stage 16-bit-instruction / 32-bit-data core. It detects load-use hazards, squashes wrong-path instructions on an EX-stage redirect, and freezes the whole pipe while data memory is busy. It also drains the pipe and parks the core on `halt`. It drives the enable, flush and bubble controls of the PC, F/D and D/X pipeline registers, replacing the ad-hoc `rst | flush` gating on those registers.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_detect.sv | 17 +
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipe_ctrl_pkg;

    localparam int          REG_W     = 3;
    localparam logic [15:0] NOP_INSTR = 16'h1000;

    typedef enum logic [2:0] {
        PC_RUN      = 3'd0,
        PC_MEM_WAIT = 3'd1,
        PC_DRAIN    = 3'd2,
        PC_HALTED   = 3'd3
    } pc_state_e;

    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic fd_flush;
        logic dx_bubble;
        logic pipe_freeze;
    } pipe_ctl_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use compare between the decode sources and the EX-stage load destination.
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic [REG_W-1:0] dec_rq,
    input  logic [REG_W-1:0] dec_rs,
    input  logic             dec_use_rq,
    input  logic             dec_use_rs,
    output logic             hazard
);

    assign hazard = ex_mem_read & ((dec_use_rq & (dec_rq == ex_write_reg)) |
                                   (dec_use_rs & (dec_rs == ex_write_reg)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: load-use stall, redirect squash, memory freeze, halt drain.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_MAX = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] dec_rq,
    input  logic [REG_W-1:0] dec_rs,
    input  logic             dec_use_rq,
    input  logic             dec_use_rs,
    input  logic             dec_halt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             dx_bubble,
    output logic             pipe_freeze,
    output logic             halted,
    output logic             halt_timeout,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
`endif
    output logic [2:0]       state
);

    localparam int DW = $clog2(DRAIN_MAX + 1);

    pc_state_e st, nxt;
    logic [DW-1:0] drain_cnt;
    logic hazard, timeout_hit;
    pipe_ctl_t ctl;

    pipe_hazard_detect u_haz (
        .ex_mem_read (ex_mem_read),
        .ex_write_reg(ex_write_reg),
        .dec_rq      (dec_rq),
        .dec_rs      (dec_rs),
        .dec_use_rq  (dec_use_rq),
        .dec_use_rs  (dec_use_rs),
        .hazard      (hazard)
    );

    // MEM_WAIT with memory released behaves exactly like RUN, so release costs no cycle.
    always_comb begin
        ctl         = '0;
        nxt         = st;
        timeout_hit = 1'b0;
        unique case (st)
            PC_RUN, PC_MEM_WAIT: begin
                if (mem_busy) begin
                    ctl.pipe_freeze = 1'b1;
                    nxt = PC_MEM_WAIT;
                end else if (ex_redirect) begin
                    ctl = '{pc_en: 1'b1, fd_en: 1'b1, fd_flush: 1'b1, dx_bubble: 1'b1, pipe_freeze: 1'b0};
                    nxt = PC_RUN;
                end else if (hazard) begin
                    ctl.dx_bubble = 1'b1;
                    nxt = PC_RUN;
                end else if (dec_halt) begin
                    ctl.fd_en    = 1'b1;
                    ctl.fd_flush = 1'b1;
                    nxt = PC_DRAIN;
                end else begin
                    ctl.pc_en = 1'b1;
                    ctl.fd_en = 1'b1;
                    nxt = PC_RUN;
                end
            end
            PC_DRAIN: begin
                if (mem_busy) begin
                    ctl.pipe_freeze = 1'b1;
                end else begin
                    ctl.fd_en     = 1'b1;
                    ctl.fd_flush  = 1'b1;
                    ctl.dx_bubble = 1'b1;
                end
                if (wb_halt) begin
                    nxt = PC_HALTED;
                end else if (!mem_busy && drain_cnt == DW'(DRAIN_MAX - 1)) begin
                    nxt = PC_HALTED;
                    timeout_hit = 1'b1;
                end
            end
            PC_HALTED: begin
                ctl.fd_flush  = 1'b1;
                ctl.dx_bubble = 1'b1;
            end
            default: nxt = PC_RUN;
        endcase
        if (rst) ctl = '{pc_en: 1'b0, fd_en: 1'b1, fd_flush: 1'b1, dx_bubble: 1'b1, pipe_freeze: 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st           <= PC_RUN;
            drain_cnt    <= '0;
            halted       <= 1'b0;
            halt_timeout <= 1'b0;
        end else begin
            st     <= nxt;
            halted <= (nxt == PC_HALTED);
            if (timeout_hit) halt_timeout <= 1'b1;
            if (st != PC_DRAIN) drain_cnt <= '0;
            else if (!mem_busy) drain_cnt <= drain_cnt + 1'b1;
        end
    end

    assign pc_en       = ctl.pc_en;
    assign fd_en       = ctl.fd_en;
    assign fd_flush    = ctl.fd_flush;
    assign dx_bubble   = ctl.dx_bubble;
    assign pipe_freeze = ctl.pipe_freeze;
    assign state       = st;

`ifdef PIPE_CTRL_PERF_EN
    // The control word alone identifies each event: a stall is the only bubble without a flush.
    logic stall_evt, flush_evt;
    assign stall_evt = ~ctl.pc_en & ~ctl.fd_en & ctl.dx_bubble & ~ctl.fd_flush;
    assign flush_evt = ctl.pc_en & ctl.fd_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else if (st != PC_HALTED) begin
            if (stall_evt && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush_evt && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
            if (ctl.pipe_freeze && freeze_cnt != '1) freeze_cnt <= freeze_cnt + 1'b1;
        end
    end
`endif

endmodule
